// File: rtl/sieve_ctrl_pkg.sv
// sieve_ctrl_pkg: state encoding shared by the sieve sequencer.
// Rev 1.0
`default_nettype none

package sieve_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_READ  = 3'd2,
      S_CHECK = 3'd3,
      S_EMIT  = 3'd4,
      S_MARK  = 3'd5,
      S_NEXT  = 3'd6,
      S_DONE  = 3'd7
   } state_t;

endpackage

`default_nettype wire

// File: rtl/sieve_ctrl.sv
// sieve_ctrl: Sieve of Eratosthenes sequencer driving an external 1-bit blockram.
// Rev 1.0
`default_nettype none

module sieve_ctrl
   import sieve_ctrl_pkg::*;
#(
   parameter int ADDR = 8
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            prime_valid,
   input  logic            prime_ready,
   output logic [ADDR-1:0] prime_data,
   output logic [ADDR-1:0] ram_addr,
   output logic            ram_wr,
   output logic            ram_din,
   input  logic            ram_dout
);

   localparam int PW = ADDR + 1;
   localparam int MW = 2 * ADDR + 1;
   localparam logic [PW-1:0] N_P    = PW'(1 << ADDR);
   localparam logic [PW-1:0] C_LAST = PW'((1 << ADDR) - 1);
   localparam logic [MW-1:0] N_M    = MW'(1 << ADDR);

   state_t          state_q, state_d;
   logic [PW-1:0]   c_q, c_d;
   logic [PW-1:0]   p_q, p_d;
   logic [MW-1:0]   m_q, m_d;
   logic [ADDR-1:0] prime_data_q, prime_data_d;
   logic [MW-1:0]   pp;
   logic [MW-1:0]   m_next;
   logic [PW-1:0]   p_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         c_q          <= '0;
         p_q          <= '0;
         m_q          <= '0;
         prime_data_q <= '0;
      end else begin
         state_q      <= state_d;
         c_q          <= c_d;
         p_q          <= p_d;
         m_q          <= m_d;
         prime_data_q <= prime_data_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      c_d          = c_q;
      p_d          = p_q;
      m_d          = m_q;
      prime_data_d = prime_data_q;
      ram_addr     = '0;
      ram_wr       = 1'b0;
      ram_din      = 1'b0;
      // Wide enough that p*p and m+p never wrap before the compare against N.
      pp           = MW'(p_q) * MW'(p_q);
      m_next       = m_q + MW'(p_q);
      p_inc        = p_q + PW'(1);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               c_d     = '0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            ram_wr   = 1'b1;
            ram_addr = c_q[ADDR-1:0];
            c_d      = c_q + PW'(1);
            if (c_q == C_LAST) begin
               p_d     = PW'(2);
               state_d = S_READ;
            end
         end
         S_READ: begin
            ram_addr = p_q[ADDR-1:0];
            state_d  = S_CHECK;
         end
         S_CHECK: begin
            if (ram_dout) begin
               state_d = S_NEXT;
            end else begin
               prime_data_d = p_q[ADDR-1:0];
               state_d      = S_EMIT;
            end
         end
         S_EMIT: begin
            if (prime_ready) begin
               if (pp < N_M) begin
                  m_d     = pp;
                  state_d = S_MARK;
               end else begin
                  state_d = S_NEXT;
               end
            end
         end
         S_MARK: begin
            ram_wr   = 1'b1;
            ram_din  = 1'b1;
            ram_addr = m_q[ADDR-1:0];
            if (m_next >= N_M) state_d = S_NEXT;
            else               m_d     = m_next;
         end
         S_NEXT: begin
            p_d = p_inc;
            if (p_inc == N_P) state_d = S_DONE;
            else              state_d = S_READ;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign prime_valid = (state_q == S_EMIT);
   assign prime_data  = prime_data_q;

endmodule

`default_nettype wire
